pwm_capture: RTL and testbench

- Measures an incoming PWM waveform; the receiving end of the timer-driven PWM generators in this codebase.
- Synchronises `pwm_in` into the `clk` domain and counts clock cycles between edges.
- Reports the period and the high time of each complete cycle with a one-cycle `valid` strobe.
- Flags stuck or too-slow inputs with a `timeout` strobe.

---
 rtl/pwm_capture_pkg.sv | 20 ++
 rtl/pwm_sync_edge.sv | 72 +++++++
 rtl/pwm_capture.sv | 129 ++++++++++++
 tb/tb_pwm_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM state encoding
// and the counter saturation value derived from the counter width.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } cap_state_e;

    localparam int unsigned CAP_BITS_DEFAULT = 32'd15;

    // All-ones value of a bits-wide counter; reaching it abandons the capture.
    function automatic int unsigned sat_value(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    localparam int unsigned CAP_SAT_DEFAULT = sat_value(CAP_BITS_DEFAULT);

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronises the asynchronous PWM input and detects its edges.
// Define PWM_CAPTURE_DEGLITCH_EN to insert a 2-sample agreement filter before edge detect.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    import pwm_capture_pkg::*;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_s;
    logic                   lvl_s;
    logic                   lvl_prev_q;

    // Synchroniser chain; the newest sample enters at bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    assign s_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_DEGLITCH_EN
    logic f_q;
    logic f_d;

    // The last two synchronised samples must agree before the filtered level follows them.
    always_comb begin
        f_d = f_q;
        if (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]) begin
            f_d = s_s;
        end else begin
            f_d = f_q;
        end
    end

    // Filtered level register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_q <= 1'b0;
        end else begin
            f_q <= f_d;
        end
    end

    assign lvl_s = f_q;
`else
    assign lvl_s = s_s;
`endif

    // One-cycle delayed copy of the level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_prev_q <= 1'b0;
        end else begin
            lvl_prev_q <= lvl_s;
        end
    end

    assign level_o = lvl_s;
    assign rise_o  = lvl_s & ~lvl_prev_q;
    assign fall_o  = ~lvl_s & lvl_prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time measurement with saturation timeout.
// Optional input deglitch filter is enabled by defining PWM_CAPTURE_DEGLITCH_EN.
module pwm_capture #(
    parameter int BITS        = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            pwm_in,
    output logic [BITS-1:0] period,
    output logic [BITS-1:0] high_time,
    output logic            valid,
    output logic            timeout,
    output logic            busy
);
    import pwm_capture_pkg::*;

    localparam logic [BITS-1:0] CNT_SAT  = BITS'(sat_value(BITS));
    localparam logic [BITS-1:0] CNT_ZERO = {BITS{1'b0}};
    localparam logic [BITS-1:0] CNT_ONE  = {{(BITS-1){1'b0}}, 1'b1};

    cap_state_e      state_q, state_d;
    logic [BITS-1:0] cnt_q, cnt_d;
    logic [BITS-1:0] hi_lat_q, hi_lat_d;
    logic [BITS-1:0] period_q, period_d;
    logic [BITS-1:0] high_q, high_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;
    logic            level_s, rise_s, fall_s;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .pwm_i  (pwm_in),
        .level_o(level_s),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    // Next-state logic; a terminating edge takes priority over saturation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_lat_d  = hi_lat_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = CNT_ZERO;
                    if (rise_s && level_s) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_HIGH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    if (fall_s) begin
                        hi_lat_d = cnt_q;
                        cnt_d    = cnt_q + CNT_ONE;
                        state_d  = ST_LOW;
                    end else if (cnt_q == CNT_SAT) begin
                        timeout_d = 1'b1;
                        cnt_d     = CNT_ZERO;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        period_d = cnt_q;
                        high_d   = hi_lat_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                        state_d  = ST_HIGH;
                    end else if (cnt_q == CNT_SAT) begin
                        timeout_d = 1'b1;
                        cnt_d     = CNT_ZERO;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            hi_lat_q  <= CNT_ZERO;
            period_q  <= CNT_ZERO;
            high_q    <= CNT_ZERO;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_lat_q  <= hi_lat_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign busy      = (state_q == ST_HIGH) || (state_q == ST_LOW);

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: expected measurements are derived from the
// recorded input waveform by run-length analysis, independent of the RTL structure.
module tb_pwm_capture;
    localparam int BITS = 8;
    localparam int SYNC = 2;
    localparam int SAT  = 255;
`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int LAT = SYNC + 2;
    localparam bit DG  = 1'b1;
`else
    localparam int LAT = SYNC + 1;
    localparam bit DG  = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n, enable, pwm_in;
    logic [BITS-1:0] period, high_time;
    logic            valid, timeout, busy;

    pwm_capture #(.BITS(BITS), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_in),
        .period(period), .high_time(high_time), .valid(valid),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observations collected at the falling edge.
    int got_p[$], got_h[$], got_t[$];
    int n_to = 0, to_t = -1, n_both = 0, busy_low = 0;
    bit busy_watch = 1'b0;
    always @(negedge clk) begin
        if (valid) begin
            got_p.push_back(int'(period));
            got_h.push_back(int'(high_time));
            got_t.push_back(cyc);
        end
        if (timeout) begin
            n_to++;
            to_t = cyc;
        end
        if (valid && timeout) n_both++;
        if (busy_watch && !busy) busy_low++;
    end

    // Recorded stimulus: one entry per driven clock cycle.
    bit wf[$];
    bit en_ok[$];
    int rt[$];
    int n_cmp = 0, n_bad = 0;
    int last_p = 0, last_h = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input bit lvl);
        if (lvl && !pwm_in) rt.push_back(cyc);
        pwm_in = lvl;
        wf.push_back(lvl);
        en_ok.push_back(enable);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_hl(input int h, input int l);
        repeat (h) tick(1'b1);
        repeat (l) tick(1'b0);
    endtask

    task automatic clear_q();
        wf.delete(); en_ok.delete(); rt.delete();
        got_p.delete(); got_h.delete(); got_t.delete();
    endtask

    // Expected measurements: every rise-to-rise interval of the (optionally filtered)
    // waveform that contains no disabled cycle.
    task automatic check_phase(input string tag);
        int ep[$], eh[$];
        int r = -1, fl = -1, n;
        bit fp = 1'b0, nf, broken = 1'b0;
        for (int i = 0; i < wf.size(); i++) begin
            if (DG) nf = (i > 0 && wf[i] == wf[i-1]) ? wf[i] : fp;
            else    nf = wf[i];
            if (!en_ok[i]) broken = 1'b1;
            if (nf && !fp) begin
                if (r >= 0 && !broken) begin
                    ep.push_back(i - r);
                    eh.push_back(fl - r);
                end
                r = i; fl = -1; broken = 1'b0;
            end else if (!nf && fp) begin
                fl = i;
            end
            fp = nf;
        end
        chk({tag, "_count"}, got_p.size(), ep.size());
        n = (got_p.size() < ep.size()) ? got_p.size() : ep.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_period%0d", tag, i), got_p[i], ep[i]);
            chk($sformatf("%s_high%0d", tag, i), got_h[i], eh[i]);
        end
        if (ep.size() > 0) begin
            last_p = ep[ep.size()-1];
            last_h = eh[eh.size()-1];
        end
    endtask

    // Trailing rise closes the last measurement, then a short disable returns the FSM to IDLE.
    task automatic end_phase(input string tag);
        repeat (5) tick(1'b1);
        repeat (6) tick(1'b0);
        enable = 1'b0;
        repeat (2) tick(1'b0);
        enable = 1'b1;
        check_phase(tag);
        clear_q();
    endtask

    initial begin
        int nv, nt, h, l;
        reset_n = 1'b0; enable = 1'b0; pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", int'(period), 0);
        chk("rst_high", int'(high_time), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1; enable = 1'b1;
        @(posedge clk);
        #1;

        // Directed 30/70 stream, then a duty change to 80/20.
        drive_hl(30, 70);
        busy_watch = 1'b1;
        repeat (4) drive_hl(30, 70);
        busy_watch = 1'b0;
        chk("dir_valids_after_5", got_p.size(), 4);
        chk("dir_busy_low", busy_low, 0);
        chk("dir_latency", (got_t.size() > 0 && rt.size() > 1) ? got_t[0] - rt[1] : -1, LAT);
        repeat (2) drive_hl(80, 20);
        end_phase("dir");

        // Randomised duty/period.
        repeat (8) begin
            h = int'($urandom_range(60, 2));
            l = int'($urandom_range(60, 2));
            drive_hl(h, l);
        end
        end_phase("rnd");

        // Enable dropped for 10 cycles mid-LOW.
        drive_hl(30, 70);
        repeat (30) tick(1'b1);
        repeat (20) tick(1'b0);
        enable = 1'b0;
        nv = got_p.size();
        nt = n_to;
        repeat (10) tick(1'b0);
        chk("dis_busy", int'(busy), 0);
        chk("dis_no_valid", got_p.size(), nv);
        chk("dis_no_timeout", n_to, nt);
        enable = 1'b1;
        repeat (40) tick(1'b0);
        repeat (2) drive_hl(30, 70);
        end_phase("dis");

        // Single-cycle low glitch inside a 40/60 waveform.
        drive_hl(40, 60);
        repeat (20) tick(1'b1);
        tick(1'b0);
        repeat (19) tick(1'b1);
        repeat (60) tick(1'b0);
        chk("glitch_valids", got_p.size(), DG ? 1 : 2);
        end_phase("glitch");

        // Stuck high then stuck low: both saturate.
        n_to = 0;
        repeat (300) tick(1'b1);
        chk("to_hi_count", n_to, 1);
        chk("to_hi_time", (rt.size() > 0) ? to_t - rt[0] : -1, LAT + SAT);
        chk("to_hi_period", int'(period), last_p);
        chk("to_hi_high", int'(high_time), last_h);
        chk("to_hi_busy", int'(busy), 0);
        repeat (10) tick(1'b0);
        repeat (10) tick(1'b1);
        repeat (300) tick(1'b0);
        chk("to_lo_count", n_to, 2);
        chk("to_no_valid", got_p.size(), 0);
        clear_q();

        // Asynchronous reset while in HIGH.
        drive_hl(30, 70);
        repeat (20) tick(1'b1);
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_high", int'(high_time), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_timeout", int'(timeout), 0);
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_q();
        repeat (2) drive_hl(30, 70);
        end_phase("post_rst");

        chk("valid_and_timeout", n_both, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
